cmp_seq_wide: RTL
=================

Name: cmp_seq_wide

Overview:
- Multi-cycle comparator controller for wide unsigned operands.
- Compares NBYTES-byte operands one byte per cycle, most significant byte first, using a single shared 8-bit comparator.
- Stops at the first unequal byte and reports eq/gt/lt with a done pulse.
- Sits between the compare-request logic and the 8-bit comparator datapath; trades latency for area against a full-width comparator.

Parameters:
- NBYTES, 4, number of bytes per operand; legal range 2..16.
- IDXW, $clog2(NBYTES), width of the byte index and count; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request a compare; accepted only when busy=0
- abort  in  1  cancel the operation in progress
- a  in  8*NBYTES  operand A, unsigned, byte NBYTES-1 is most significant
- b  in  8*NBYTES  operand B, same format as a
- busy  out  1  high in states CMP and DONE
- done  out  1  one-cycle pulse; result valid
- eq  out  1  A == B
- gt  out  1  A > B
- lt  out  1  A < B
- bytes_used  out  IDXW+1  number of bytes examined in the last completed compare

Behaviour:
- Reset values (async, rst=1): state=IDLE, busy=0, done=0, eq=gt=lt=0, bytes_used=0, operand registers and idx=0. Reset mid-operation abandons the compare with no done pulse.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - start=1 and abort=0: capture a and b into internal registers, set idx=NBYTES-1, clear eq/gt/lt to 0, go to CMP.
  - a and b are sampled only at acceptance; later changes are ignored.
- CMP:
  - Each cycle, drive the shared comparator with byte idx of the captured operands.
  - Byte gt=1: set gt=1, set bytes_used=NBYTES-idx, go to DONE.
  - Byte lt=1: set lt=1, set bytes_used=NBYTES-idx, go to DONE.
  - Byte eq=1 and idx=0: set eq=1, set bytes_used=NBYTES, go to DONE.
  - Byte eq=1 and idx>0: decrement idx, stay in CMP.
  - idx never wraps.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: start accepted at edge t -> done high in cycle t+k+1, where k is the number of bytes examined (1..NBYTES). Minimum 2 cycles, maximum NBYTES+1 cycles.
- Back-to-back: start is not accepted in DONE (busy=1). The earliest next accept is the cycle after done, so the throughput floor is one compare per k+2 cycles.
- start while busy=1: ignored, no queuing.
- abort:
  - In CMP: go to IDLE next cycle, no done pulse, eq/gt/lt stay 0, bytes_used unchanged.
  - In DONE: no effect; done still pulses and the result stands.
  - In IDLE: no effect.
  - abort and start together in IDLE: abort wins, start ignored.
- Result holding: eq/gt/lt and bytes_used hold their values from DONE until the next accepted start, which clears eq/gt/lt. After any completed compare, exactly one of eq/gt/lt is high. All three are 0 before the first completion and after an abort.
- All outputs are registered; no combinational path from start/a/b to the outputs.

Decomposition:
- Shared package (cmp_pkg):
  - FSM state enum cmp_state_t {IDLE, CMP, DONE}.
  - Localparam BYTE_W=8.
- Sub-module: comparator_8bit_ds, instantiated exactly once as the per-byte datapath. The byte mux and all control stay in cmp_seq_wide.

Test Plan (NBYTES=4):
- Reset then idle: rst pulsed while in CMP -> busy=0, done=0, eq=gt=lt=0, bytes_used=0 immediately, with no clock edge needed.
- Equal operands: a=b=32'hDEADBEEF, start -> done in cycle 5 after the accept edge, eq=1, gt=lt=0, bytes_used=4.
- MSB decides: a=32'h80000000, b=32'h7FFFFFFF -> done at cycle 2, gt=1, bytes_used=1.
- LSB decides: a=32'h12345600, b=32'h12345601 -> done at cycle 5, lt=1, bytes_used=4.
- Abort and ignored start:
  - start with a=32'h11223344, b=32'h11223355.
  - Pulse start again during CMP -> ignored.
  - Assert abort at the 2nd CMP cycle -> no done pulse, eq=gt=lt=0, busy=0 next cycle.
  - Then start with a=b=0 -> eq=1 after 5 cycles.
- Simultaneous events and back-to-back:
  - abort+start together in IDLE -> stays IDLE.
  - start held high continuously -> compares accepted on the cycle after each done.
  - a and b changed mid-compare -> result reflects the captured values only.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the byte-serial wide comparator.
// Imported by the controller and its per-byte comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/comparator_8bit_ds.sv
// Single 8-bit unsigned magnitude comparator.
// This is the shared per-byte datapath that the wide controller steps through.
module comparator_8bit_ds
  import cmp_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  output logic              eq_o,
  output logic              gt_o,
  output logic              lt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);
  assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/cmp_seq_wide.sv
// Wide unsigned comparator that checks one byte per cycle, MSB first,
// and stops at the first unequal byte. All outputs come from registers.
module cmp_seq_wide
  import cmp_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int IDXW   = $clog2(NBYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic [IDXW:0]            bytes_used
);

  cmp_state_t                 state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [BYTE_W*NBYTES-1:0]   a_q, a_d, b_q, b_d;
  logic                       eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic [IDXW:0]              bu_q, bu_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  logic [BYTE_W-1:0]          a_byte, b_byte;
  logic                       byte_eq, byte_gt, byte_lt;
  logic [IDXW:0]              used_now;

  assign a_byte   = a_q[idx_q*BYTE_W +: BYTE_W];
  assign b_byte   = b_q[idx_q*BYTE_W +: BYTE_W];
  // idx counts down from the MSB, so bytes examined so far is NBYTES - idx.
  assign used_now = (IDXW+1)'(NBYTES) - {1'b0, idx_q};

  comparator_8bit_ds u_cmp8 (
    .a_i  (a_byte),
    .b_i  (b_byte),
    .eq_o (byte_eq),
    .gt_o (byte_gt),
    .lt_o (byte_lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    bu_d    = bu_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDXW'(NBYTES - 1);
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        // Abort takes priority over a decision made in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (byte_gt) begin
          gt_d    = 1'b1;
          bu_d    = used_now;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (byte_lt) begin
          lt_d    = 1'b1;
          bu_d    = used_now;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (byte_eq) begin
          if (idx_q == '0) begin
            eq_d    = 1'b1;
            bu_d    = used_now;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      bu_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      bu_q    <= bu_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign eq         = eq_q;
  assign gt         = gt_q;
  assign lt         = lt_q;
  assign bytes_used = bu_q;

endmodule
